// File: rtl/seq_divider.sv
// seq_divider: iterative restoring unsigned divider, one quotient bit per clock
module seq_divider #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] r_q, r_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic             dbz_q, dbz_d;
    logic [WIDTH:0]   r_sh;
    logic [WIDTH:0]   diff;

    // Next-state, iteration datapath and result capture
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        r_d     = r_q;
        q_d     = q_q;
        dvs_d   = dvs_q;
        quo_d   = quo_q;
        rem_d   = rem_q;
        dbz_d   = dbz_q;
        r_sh    = {r_q, q_q[WIDTH-1]};
        // The partial remainder stays below the divisor, so the shifted value is below
        // twice the divisor and the top bit of the trial difference is exactly the borrow.
        diff    = r_sh - {1'b0, dvs_q};
        if (state_q != RUN) begin
            state_d = IDLE;
            if (start) begin
                if (divisor == '0) begin
                    state_d = DONE;
                    quo_d   = '1;
                    rem_d   = dividend;
                    dbz_d   = 1'b1;
                end else begin
                    state_d = RUN;
                    cnt_d   = CW'(WIDTH);
                    r_d     = '0;
                    q_d     = dividend;
                    dvs_d   = divisor;
                end
            end
        end else begin
            r_d   = diff[WIDTH] ? r_sh[WIDTH-1:0] : diff[WIDTH-1:0];
            q_d   = {q_q[WIDTH-2:0], ~diff[WIDTH]};
            cnt_d = cnt_q - CW'(1);
            if (cnt_q == CW'(1)) begin
                state_d = DONE;
                quo_d   = q_d;
                rem_d   = r_d;
                dbz_d   = 1'b0;
            end
        end
    end

    // State and datapath registers with asynchronous clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            r_q     <= '0;
            q_q     <= '0;
            dvs_q   <= '0;
            quo_q   <= '0;
            rem_q   <= '0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            r_q     <= r_d;
            q_q     <= q_d;
            dvs_q   <= dvs_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            dbz_q   <= dbz_d;
        end
    end

    assign busy        = state_q == RUN;
    assign done        = state_q == DONE;
    assign quotient    = quo_q;
    assign remainder   = rem_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_divider.sv
// tb_seq_divider: scoreboard bench for seq_divider with directed and random stimulus
module tb_seq_divider;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] dividend = '0;
    logic [W-1:0] divisor = '0;
    logic         busy, done, div_by_zero;
    logic [W-1:0] quotient, remainder;

    seq_divider #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .dividend(dividend), .divisor(divisor),
        .busy(busy), .done(done), .quotient(quotient), .remainder(remainder),
        .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] a, b, q, r;
        logic         z;
        int           at;
    } exp_t;

    exp_t         sb[$];
    int           cyc = 0;
    int           next_free = 0;
    int           busy_lo = 1;
    int           busy_hi = 0;
    int           checks = 0;
    int           errors = 0;
    logic [W-1:0] hq = '0, hr = '0;
    logic         hz = 1'b0;

    // Cycle index: after rising edge k the bench sees cyc == k
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
        end
    endtask

    // Drive inputs for the next rising edge and predict whether that edge accepts them
    task automatic drive(input logic s, input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t e;
        int   acc;
        @(negedge clk);
        start = s;
        dividend = a;
        divisor = b;
        acc = cyc + 1;
        if (s && rst_n && acc >= next_free) begin
            e.a = a;
            e.b = b;
            e.z = (b == 0);
            e.q = (b == 0) ? '1 : a / b;
            e.r = (b == 0) ? a : a % b;
            e.at = (b == 0) ? acc : acc + W;
            if (b != 0) begin
                busy_lo = acc;
                busy_hi = acc + W - 1;
            end
            next_free = e.at + 1;
            sb.push_back(e);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, W'($urandom), W'($urandom));
    endtask

    task automatic do_reset(input int n);
        @(negedge clk);
        start = 1'b0;
        rst_n = 1'b0;
        sb.delete();
        next_free = 0;
        busy_lo = 1;
        busy_hi = 0;
        hq = '0;
        hr = '0;
        hz = 1'b0;
        repeat (n) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Monitor: compares handshake and results against the scoreboard each cycle
    always @(negedge clk) begin
        exp_t e;
        #1;
        chk("busy", busy, (cyc >= busy_lo && cyc <= busy_hi));
        chk("busy_and_done", busy & done, 0);
        chk("done", done, (sb.size() > 0 && sb[0].at == cyc));
        if (sb.size() > 0 && sb[0].at <= cyc) begin
            e = sb.pop_front();
            hq = e.q;
            hr = e.r;
            hz = e.z;
            if (done && !e.z) begin
                chk("invariant", longint'(quotient) * e.b + remainder, e.a);
                chk("rem_lt_div", remainder < e.b, 1);
            end
        end
        chk("quotient", quotient, hq);
        chk("remainder", remainder, hr);
        chk("div_by_zero", div_by_zero, hz);
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        idle(2);
        drive(1'b1, 8'd100, 8'd7);
        idle(W + 2);
        drive(1'b1, 8'd255, 8'd1);
        idle(W + 2);
        drive(1'b1, 8'd5, 8'd9);
        idle(W + 2);
        drive(1'b1, 8'd255, 8'd255);
        idle(W + 2);
        drive(1'b1, 8'd37, 8'd0);
        idle(3);
        drive(1'b1, 8'd100, 8'd7);
        idle(2);
        drive(1'b1, 8'd50, 8'd5);
        idle(W + 2);
        drive(1'b1, 8'd200, 8'd3);
        repeat (W + 1) drive(1'b1, 8'd81, 8'd9);
        idle(W + 2);
        drive(1'b1, 8'd100, 8'd7);
        idle(3);
        do_reset(1);
        drive(1'b1, 8'd9, 8'd2);
        idle(W + 2);
        drive(1'b1, 8'd0, 8'd0);
        drive(1'b1, 8'd0, 8'd200);
        idle(W + 2);
        for (int i = 0; i < 20000; i++) begin
            int           sel;
            logic [W-1:0] a, b;
            sel = int'($urandom_range(0, 7));
            a = (sel == 7) ? '1 : W'($urandom);
            b = (sel == 0) ? '0 : (sel == 1) ? 8'd1 : (sel == 2) ? W'($urandom_range(1, 3)) : W'($urandom);
            drive($urandom_range(0, 3) != 0, a, b);
        end
        idle(W + 4);
        chk("scoreboard_empty", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
